// File: rtl/uart_frame_sender.sv
// UART frame sender: two header bytes, DATA_NUM payload bytes pulled from a FIFO,
// then a modulo-256 checksum byte, all sent 8N1 LSB-first on a single TX line.
module uart_frame_sender #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [9:0]  DATA_NUM     = 10'd405,
    parameter logic [7:0]  HEAD0        = 8'hA5,
    parameter logic [7:0]  HEAD1        = 8'h5A
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_start,
    input  logic [7:0] in_fifo_data,
    input  logic       in_fifo_empty,
    output logic       out_uart_send_start,
    output logic       out_uart_send_sig,
    output logic       out_tx,
    output logic       out_busy,
    output logic       out_done,
    output logic       out_underrun
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] ClkLast = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {StIdle, StHead, StFetch, StData, StCsum, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
    logic [3:0]      bit_idx_q, bit_idx_d;
    logic            head_sel_q, head_sel_d;
    logic [2:0]      fetch_cnt_q, fetch_cnt_d;
    logic [9:0]      byte_cnt_q, byte_cnt_d;
    logic [7:0]      csum_q, csum_d;
    logic [7:0]      data_q, data_d;
    logic            underrun_q, underrun_d;

    logic [7:0] tx_byte;
    logic [7:0] fetch_byte;
    logic       tx_bit;
    logic       serial_active;
    logic       bit_end;
    logic       byte_end;

    assign serial_active = (state_q == StHead) || (state_q == StData) || (state_q == StCsum);
    assign bit_end       = (clk_cnt_q == ClkLast);
    assign byte_end      = bit_end && (bit_idx_q == 4'd9);
    assign fetch_byte    = in_fifo_empty ? 8'h00 : in_fifo_data;

    always_comb begin
        tx_byte = data_q;
        if (state_q == StHead) begin
            tx_byte = head_sel_q ? HEAD1 : HEAD0;
        end else if (state_q == StCsum) begin
            tx_byte = csum_q;
        end
        // Bit slot 0 is the start bit, 9 the stop bit, 1..8 carry data LSB first.
        if (bit_idx_q == 4'd0) begin
            tx_bit = 1'b0;
        end else if (bit_idx_q >= 4'd9) begin
            tx_bit = 1'b1;
        end else begin
            tx_bit = tx_byte[3'(bit_idx_q - 4'd1)];
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        head_sel_d  = head_sel_q;
        fetch_cnt_d = fetch_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        csum_d      = csum_q;
        data_d      = data_q;
        underrun_d  = underrun_q;

        // The bit timer wraps to zero at each byte end, so consecutive bytes need no reload.
        if (serial_active) begin
            if (bit_end) begin
                clk_cnt_d = '0;
                bit_idx_d = byte_end ? 4'd0 : bit_idx_q + 4'd1;
            end else begin
                clk_cnt_d = clk_cnt_q + CntW'(1);
            end
        end

        case (state_q)
            StIdle: begin
                if (in_start) begin
                    state_d     = StHead;
                    clk_cnt_d   = '0;
                    bit_idx_d   = 4'd0;
                    head_sel_d  = 1'b0;
                    fetch_cnt_d = 3'd0;
                    byte_cnt_d  = 10'd0;
                    csum_d      = 8'h00;
                    underrun_d  = 1'b0;
                end
            end
            StHead: begin
                if (byte_end) begin
                    head_sel_d = ~head_sel_q;
                    if (head_sel_q) begin
                        state_d     = StFetch;
                        fetch_cnt_d = 3'd0;
                    end
                end
            end
            StFetch: begin
                fetch_cnt_d = fetch_cnt_q + 3'd1;
                if (fetch_cnt_q == 3'd7) begin
                    data_d     = fetch_byte;
                    csum_d     = csum_q + fetch_byte;
                    underrun_d = underrun_q | in_fifo_empty;
                    byte_cnt_d = byte_cnt_q + 10'd1;
                    state_d    = StData;
                end
            end
            StData: begin
                if (byte_end) begin
                    state_d = (byte_cnt_q == DATA_NUM) ? StCsum : StFetch;
                end
            end
            StCsum: begin
                if (byte_end) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q     <= StIdle;
            clk_cnt_q   <= '0;
            bit_idx_q   <= 4'd0;
            head_sel_q  <= 1'b0;
            fetch_cnt_q <= 3'd0;
            byte_cnt_q  <= 10'd0;
            csum_q      <= 8'h00;
            data_q      <= 8'h00;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            head_sel_q  <= head_sel_d;
            fetch_cnt_q <= fetch_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            csum_q      <= csum_d;
            data_q      <= data_d;
            underrun_q  <= underrun_d;
        end
    end

    assign out_tx              = serial_active ? tx_bit : 1'b1;
    assign out_busy            = serial_active || (state_q == StFetch);
    assign out_done            = (state_q == StDone);
    assign out_uart_send_sig   = (state_q == StFetch) && !fetch_cnt_q[2];
    // Read request stays up across intermediate DATA bytes; drops once the last byte is fetched.
    assign out_uart_send_start = (state_q == StFetch) ||
                                 ((state_q == StData) && (byte_cnt_q != DATA_NUM));
    assign out_underrun        = underrun_q;

endmodule

// File: tb/tb_uart_frame_sender.sv
// Directed bench for uart_frame_sender with CLKS_PER_BIT=4, DATA_NUM=3; decodes the TX
// line from a per-cycle log and models the FIFO from the read-clock strobes.
module tb_uart_frame_sender;

    logic       in_clk = 1'b0;
    logic       in_rst = 1'b1;
    logic       in_start = 1'b0;
    logic [7:0] in_fifo_data = 8'h00;
    logic       in_fifo_empty = 1'b0;
    logic       out_uart_send_start, out_uart_send_sig, out_tx, out_busy, out_done;
    logic       out_underrun;

    uart_frame_sender #(
        .CLKS_PER_BIT(4),
        .DATA_NUM    (10'd3),
        .HEAD0       (8'hA5),
        .HEAD1       (8'h5A)
    ) dut (
        .in_clk             (in_clk),
        .in_rst             (in_rst),
        .in_start           (in_start),
        .in_fifo_data       (in_fifo_data),
        .in_fifo_empty      (in_fifo_empty),
        .out_uart_send_start(out_uart_send_start),
        .out_uart_send_sig  (out_uart_send_sig),
        .out_tx             (out_tx),
        .out_busy           (out_busy),
        .out_done           (out_done),
        .out_underrun       (out_underrun)
    );

    always #5 in_clk = ~in_clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fifo_mem [3];
    logic [2:0] empty_mask;
    logic       tx_log [0:399];
    logic [7:0] got [6];
    logic [7:0] exp_b [6];
    int         frame_len, done_cnt, sig_cycles, sig_rises, ss_cycles, ss_bad, frame_err;

    // Byte start offsets: headers, three payload bytes each behind an 8-cycle fetch, checksum.
    int offs [6] = '{0, 40, 88, 136, 184, 224};

    task automatic start_frame();
        @(negedge in_clk);
        in_start = 1'b1;
        @(negedge in_clk);
        in_start = 1'b0;
    endtask

    // Runs from the first frame cycle (current negedge) until out_done or max_cyc cycles.
    task automatic run_frame(input int max_cyc, input bit poke);
        logic prev_sig = 1'b0;
        frame_len = -1; done_cnt = 0; sig_cycles = 0; sig_rises = 0;
        ss_cycles = 0; ss_bad = 0; frame_err = 0;
        for (int i = 0; i < 400; i++) tx_log[i] = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            if (c > 0) @(negedge in_clk);
            tx_log[c] = out_tx;
            if (out_uart_send_sig) begin
                sig_cycles++;
                if (!prev_sig) begin
                    if (sig_rises < 3) begin
                        in_fifo_data  = fifo_mem[sig_rises];
                        in_fifo_empty = empty_mask[sig_rises];
                    end
                    sig_rises++;
                end
            end
            prev_sig = out_uart_send_sig;
            if (out_uart_send_start) begin
                ss_cycles++;
                if (c < 80 || c >= 224) ss_bad++;
            end
            in_start = poke && (c == 100);
            if (out_done) begin
                done_cnt++;
                frame_len = c;
                if (poke) in_start = 1'b1;
                break;
            end
        end
        in_fifo_empty = 1'b0;
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 8; j++) got[k][j] = tx_log[offs[k] + 6 + 4 * j];
            if (tx_log[offs[k] + 2] !== 1'b0 || tx_log[offs[k] + 38] !== 1'b1) frame_err++;
        end
        for (int k = 0; k < 3; k++)
            for (int f = 0; f < 8; f++)
                if (tx_log[80 + 48 * k + f] !== 1'b1) frame_err++;
    endtask

    task automatic test_reset();
        in_rst = 1'b1;
        in_start = 1'b1;
        @(negedge in_clk);
        @(negedge in_clk);
        n_checks++; if (out_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got=%b exp=1", out_tx); end
        n_checks++; if (out_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", out_busy); end
        n_checks++; if (out_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", out_done); end
        n_checks++; if (out_underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun got=%b exp=0", out_underrun); end
        n_checks++; if (out_uart_send_start !== 1'b0) begin n_fail++; $display("FAIL reset_send_start got=%b exp=0", out_uart_send_start); end
        n_checks++; if (out_uart_send_sig !== 1'b0) begin n_fail++; $display("FAIL reset_send_sig got=%b exp=0", out_uart_send_sig); end
        in_start = 1'b0;
        in_rst = 1'b0;
        @(negedge in_clk);
        n_checks++; if (out_busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_priority busy got=%b exp=0", out_busy); end
    endtask

    task automatic test_basic_frame();
        fifo_mem = '{8'h01, 8'h02, 8'h03};
        empty_mask = 3'b000;
        exp_b = '{8'hA5, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h06};
        start_frame();
        n_checks++; if (out_busy !== 1'b1 || out_tx !== 1'b0) begin
            n_fail++; $display("FAIL basic_first_cycle busy=%b tx=%b exp busy=1 tx=0", out_busy, out_tx);
        end
        run_frame(300, 1'b0);
        for (int k = 0; k < 6; k++) begin
            n_checks++; if (got[k] !== exp_b[k]) begin n_fail++; $display("FAIL basic_byte%0d got=%h exp=%h", k, got[k], exp_b[k]); end
        end
        n_checks++; if (frame_len !== 264) begin n_fail++; $display("FAIL basic_len got=%0d exp=264", frame_len); end
        n_checks++; if (frame_err !== 0) begin n_fail++; $display("FAIL basic_framing got=%0d errors exp=0", frame_err); end
        n_checks++; if (sig_cycles !== 12) begin n_fail++; $display("FAIL basic_sig_cycles got=%0d exp=12", sig_cycles); end
        n_checks++; if (sig_rises !== 3) begin n_fail++; $display("FAIL basic_sig_pulses got=%0d exp=3", sig_rises); end
        n_checks++; if (ss_cycles !== 104) begin n_fail++; $display("FAIL basic_send_start_cycles got=%0d exp=104", ss_cycles); end
        n_checks++; if (ss_bad !== 0) begin n_fail++; $display("FAIL basic_send_start_head_csum got=%0d exp=0", ss_bad); end
        n_checks++; if (out_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done got=%b exp=0", out_busy); end
        @(negedge in_clk);
        n_checks++; if (out_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got=%b exp=0", out_done); end
        n_checks++; if (out_underrun !== 1'b0) begin n_fail++; $display("FAIL basic_underrun got=%b exp=0", out_underrun); end
    endtask

    task automatic test_underrun();
        fifo_mem = '{8'h01, 8'hEE, 8'h03};
        empty_mask = 3'b010;
        exp_b = '{8'hA5, 8'h5A, 8'h01, 8'h00, 8'h03, 8'h04};
        start_frame();
        run_frame(300, 1'b0);
        for (int k = 2; k < 6; k++) begin
            n_checks++; if (got[k] !== exp_b[k]) begin n_fail++; $display("FAIL underrun_byte%0d got=%h exp=%h", k, got[k], exp_b[k]); end
        end
        repeat (5) @(negedge in_clk);
        n_checks++; if (out_underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky got=%b exp=1", out_underrun); end
    endtask

    task automatic test_checksum_wrap();
        fifo_mem = '{8'hFF, 8'hFF, 8'h03};
        empty_mask = 3'b000;
        start_frame();
        n_checks++; if (out_underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_clear_on_start got=%b exp=0", out_underrun); end
        run_frame(300, 1'b0);
        n_checks++; if (got[5] !== 8'h01) begin n_fail++; $display("FAIL wrap_checksum got=%h exp=01", got[5]); end
        n_checks++; if (got[3] !== 8'hFF) begin n_fail++; $display("FAIL wrap_payload1 got=%h exp=ff", got[3]); end
        n_checks++; if (frame_len !== 264) begin n_fail++; $display("FAIL wrap_len got=%0d exp=264", frame_len); end
    endtask

    task automatic test_ignore_start();
        int extra_busy = 0;
        int extra_done = 0;
        fifo_mem = '{8'h10, 8'h20, 8'h30};
        empty_mask = 3'b000;
        start_frame();
        run_frame(300, 1'b1);
        @(negedge in_clk);
        in_start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_busy) extra_busy++;
            if (out_done) extra_done++;
            @(negedge in_clk);
        end
        n_checks++; if (frame_len !== 264) begin n_fail++; $display("FAIL ignore_len got=%0d exp=264", frame_len); end
        n_checks++; if (got[5] !== 8'h60) begin n_fail++; $display("FAIL ignore_checksum got=%h exp=60", got[5]); end
        n_checks++; if (extra_busy !== 0) begin n_fail++; $display("FAIL ignore_done_start busy_cycles got=%0d exp=0", extra_busy); end
        n_checks++; if (extra_done !== 0) begin n_fail++; $display("FAIL ignore_extra_done got=%0d exp=0", extra_done); end
    endtask

    task automatic test_reset_abort();
        fifo_mem = '{8'h11, 8'h22, 8'h33};
        empty_mask = 3'b000;
        start_frame();
        run_frame(141, 1'b0);
        in_rst = 1'b1;
        @(negedge in_clk);
        n_checks++; if (out_tx !== 1'b1) begin n_fail++; $display("FAIL abort_tx got=%b exp=1", out_tx); end
        n_checks++; if (out_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", out_busy); end
        n_checks++; if (out_uart_send_start !== 1'b0 || out_uart_send_sig !== 1'b0) begin
            n_fail++; $display("FAIL abort_strobes start=%b sig=%b exp 0 0", out_uart_send_start, out_uart_send_sig);
        end
        n_checks++; if (out_done !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", out_done); end
        in_rst = 1'b0;
        fifo_mem = '{8'h01, 8'h02, 8'h03};
        exp_b = '{8'hA5, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h06};
        start_frame();
        run_frame(300, 1'b0);
        for (int k = 0; k < 6; k++) begin
            n_checks++; if (got[k] !== exp_b[k]) begin n_fail++; $display("FAIL after_abort_byte%0d got=%h exp=%h", k, got[k], exp_b[k]); end
        end
        n_checks++; if (frame_len !== 264) begin n_fail++; $display("FAIL after_abort_len got=%0d exp=264", frame_len); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_underrun();
        test_checksum_wrap();
        test_ignore_start();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_frame_sender.md
UART_FRAME_SENDER -- requirements
Module: uart_frame_sender

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, in_clk cycles per UART bit (50 MHz / 115200).
REQ-002 Parameter DATA_NUM, default 10'd405, number of payload bytes per frame (range 1..1023).
REQ-003 Parameter HEAD0, default 8'hA5, first header byte.
REQ-004 Parameter HEAD1, default 8'h5A, second header byte.
REQ-005 Port in_clk  input  1  sole clock; all logic on its rising edge.
REQ-006 Port in_rst  input  1  reset, synchronous, active-high.
REQ-007 Port in_start  input  1  one-cycle request to send one frame.
REQ-008 Port in_fifo_data  input  8  FIFO read data (q).
REQ-009 Port in_fifo_empty  input  1  FIFO read-side empty flag.
REQ-010 Port out_uart_send_start  output  1  FIFO read request, high for the whole payload phase.
REQ-011 Port out_uart_send_sig  output  1  FIFO read-clock strobe, one pulse per payload byte.
REQ-012 Port out_tx  output  1  UART TX line, 8N1, LSB first, idle high.
REQ-013 Port out_busy  output  1  high from frame start until frame end.
REQ-014 Port out_done  output  1  one-cycle pulse at frame end.
REQ-015 Port out_underrun  output  1  sticky flag: at least one payload byte fetched while FIFO empty.

Function
REQ-016 The FSM SHALL have states IDLE, HEAD, FETCH, DATA, CSUM, DONE.
REQ-017 IDLE: in_start=1 -> HEAD on the next edge; out_busy SHALL rise and out_tx SHALL drive the start bit of HEAD0 in that same first cycle.
REQ-018 in_start SHALL be ignored whenever out_busy=1.
REQ-019 Each UART byte SHALL occupy exactly 10*CLKS_PER_BIT cycles: start bit 0, data bits [0]..[7], stop bit 1, each held CLKS_PER_BIT cycles.
REQ-020 HEAD SHALL send HEAD0 then HEAD1 back-to-back with no idle cycles, then enter FETCH.
REQ-021 FETCH SHALL last exactly 8 cycles, numbered f=0..7; out_tx=1 throughout.
REQ-022 out_uart_send_sig SHALL be 1 for f=0..3 and 0 for f=4..7; out_uart_send_start SHALL be 1 from first FETCH entry until the last payload byte's FETCH ends.
REQ-023 At f=7 the block SHALL latch in_fifo_data; if in_fifo_empty=1 at f=7, it SHALL latch 8'h00 instead and set out_underrun.
REQ-024 DATA SHALL transmit the latched byte, then return to FETCH while fewer than DATA_NUM bytes are sent, else enter CSUM with no idle cycles.
REQ-025 Payload byte counter SHALL be 10 bits, cleared on frame start; it SHALL NOT wrap within a frame.
REQ-026 Checksum SHALL be the 8-bit modulo-256 sum of all DATA_NUM latched payload bytes (substituted 8'h00 included), headers excluded; cleared on frame start.
REQ-027 CSUM SHALL transmit the checksum byte, then enter DONE.
REQ-028 DONE SHALL last one cycle: out_done=1, out_busy=0, then IDLE; in_start in the DONE cycle SHALL be ignored.
REQ-029 out_underrun SHALL clear only on reset or on acceptance of a new in_start.
REQ-030 Frame duration from first start-bit cycle to out_done SHALL be (DATA_NUM+3)*10*CLKS_PER_BIT + 8*DATA_NUM cycles.

Reset
REQ-031 On in_rst=1 the FSM SHALL go to IDLE and counters/checksum SHALL clear on the same edge.
REQ-032 Reset values: out_tx=1, out_busy=0, out_done=0, out_underrun=0, out_uart_send_start=0, out_uart_send_sig=0.
REQ-033 in_rst SHALL take priority over in_start in the same cycle.
REQ-034 Reset mid-frame SHALL abort immediately: out_tx=1 and FIFO strobes low on the next cycle, no out_done pulse.

Verification
REQ-035 CLKS_PER_BIT=4, DATA_NUM=3, FIFO bytes 01,02,03 -> out_tx serial bytes A5,5A,01,02,03,06; out_done exactly 1 cycle; frame length 6*40+24=264 cycles.
REQ-036 Same setup, FIFO bytes FF,FF,03 -> checksum byte 8'h01 (mod-256 wrap).
REQ-037 in_fifo_empty=1 at second fetch -> payload 01,00,03, checksum 04, out_underrun=1 after frame; next in_start clears it.
REQ-038 in_start pulsed mid-frame and in the DONE cycle -> ignored; exactly one frame, one out_done.
REQ-039 in_rst asserted during 2nd payload byte -> next cycle out_tx=1, out_busy=0, out_uart_send_start=0; a following in_start produces a complete correct frame.
REQ-040 Per FETCH, out_uart_send_sig high exactly 4 cycles; total 3 pulses per frame; out_uart_send_start low during HEAD and CSUM.
